umich_seqgen_pipe: RTL and testbench
====================================

# umich_seqgen_pipe

Parametrised successor to the single-bit generic sequential cell: a WIDTH-bit, DEPTH-stage registered pipeline with a priority-select input mux over N_IN candidate words and valid/ready flow control. It also carries the generic cell's synchronous clear/preset/hold controls. It sits in the generic-cell library as the mapping target for multi-bit registered select/mux structures emitted by synthesis, replacing chains of single-bit generic cells and select ops.

## Interface
- WIDTH, 8, data word width (≥1)
- N_IN, 3, number of candidate data words (≥2)
- DEPTH, 2, pipeline stages (≥1)
- PRESET_VAL, 0, WIDTH-bit word injected by preset
- clocked_on  in  1  clock, all state updates on rising edge
- clear  in  1  reset, synchronous, active-low
- data_in  in  N_IN*WIDTH  candidate words; word i = data_in[i*WIDTH +: WIDTH]
- control  in  N_IN  priority select, lowest set index wins
- in_valid  in  1  input token offered
- in_ready  out  1  input token accepted this cycle when in_valid & in_ready
- synch_clear  in  1  flush all stages
- synch_preset  in  1  with synch_clear: inject PRESET_VAL token
- synch_toggle  in  1  freeze whole pipeline (hold)
- out_valid  out  1  Q holds a valid token
- out_ready  in  1  downstream accepts when out_valid & out_ready
- Q  out  WIDTH  last-stage data
- occ  out  $clog2(DEPTH+1)  number of valid stages

Reset is synchronous and active-low, on the single clock clocked_on.

## Operation
- Selected word sel: data_in word of lowest index i with control[i]=1; if control==0, word N_IN-1.
- Stages 0..DEPTH-1, each a valid bit plus WIDTH-bit data. Stage 0 is the input and stage DEPTH-1 drives Q/out_valid.
- Stage k advances if its successor is empty or advancing. The last stage advances on out_ready. Bubbles collapse, so throughput is 1 token/cycle.
- Precedence per edge when clear=1: synch_clear > synch_toggle > normal flow.
- synch_clear=1: all valid bits cleared and no pop completes. If synch_preset=1, stage 0 instead receives PRESET_VAL with valid=1. Input not accepted. Data registers of flushed stages retain old contents.
- synch_toggle=1 (no clear): no state change. in_ready=0 and out_valid=0, so no handshake completes.
- synch_preset without synch_clear is ignored.
- Q always shows last-stage data register, including when out_valid=0.
- occ = popcount of stage valid bits, registered state, consistent with valid bits after each edge.

## Timing
- clear=0 at an edge: all valid=0 and all data registers=0 after that edge. Q=0, out_valid=0, occ=0.
- in_ready=0 combinationally while clear=0, synch_clear=1 or synch_toggle=1.
- Otherwise in_ready = ~stage0.valid | stage0 advancing. This is a combinational path from out_ready through the stall chain.
- out_valid = last.valid & ~synch_toggle.
- Latency: a token accepted at edge k with no stalls is on Q with out_valid=1 in the cycle after edge k+DEPTH-1. For DEPTH=1 that is the cycle after acceptance.
- Simultaneous push and pop on a full pipeline are both accepted. occ is unchanged.
- Reset or flush mid-transfer drops every in-flight token. No partial outputs.

## Configuration
- UMICH_SEQGEN_PARITY_EN defined: every stage carries an extra even-parity bit computed from sel at stage 0, or from PRESET_VAL on inject. This bit travels with the data and is presented on the extra output port Q_par (1 bit, reset 0).
- Undefined: no parity storage and no Q_par port. All other behaviour is identical.

## Test plan
- Reset: clear=0 for 2 edges with in_valid=1 -> Q=0, out_valid=0, occ=0, in_ready=0. Release, and in_ready=1 the next cycle.
- Priority select, WIDTH=8, N_IN=3, DEPTH=2, out_ready=1: words {0x33,0x22,0x11}, control=3'b110 -> token 0x22; control=0 -> 0x33.
- Latency and throughput: push 0x01..0x05 on consecutive edges -> out_valid=1 from 2nd cycle after the first push. Q=0x01..0x05 on consecutive cycles with no gaps.
- Backpressure: out_ready=0, push 3 tokens into DEPTH=2 -> only 2 accepted, occ=2, in_ready=0. Raise out_ready -> pop 0xA then 0xB, with a 3rd push accepted in the same cycle as the first pop.
- Flush and preset: occ=2, then synch_clear=1, synch_preset=1, PRESET_VAL=0x5A -> occ=1, 0x5A reaches Q after DEPTH-1 more edges. synch_clear alone -> occ=0, Q keeps its stale value.
- Hold: synch_toggle=1 for 3 cycles with in_valid=out_ready=1 -> in_ready=out_valid=0, occ/Q unchanged. With UMICH_SEQGEN_PARITY_EN, token 0x07 yields Q_par=1.

Source files
------------

// File: rtl/umich_seqgen_pipe.sv
// umich_seqgen_pipe: WIDTH-bit, DEPTH-stage valid/ready pipeline with priority-select input and sync clear/preset/hold.
// Define UMICH_SEQGEN_PARITY_EN to carry an even-parity bit per stage and expose it on Q_par.
module umich_seqgen_pipe #(
    parameter int WIDTH = 8,
    parameter int N_IN = 3,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] PRESET_VAL = '0
) (
    input  logic                         clocked_on,
    input  logic                         clear,
    input  logic [N_IN*WIDTH-1:0]        data_in,
    input  logic [N_IN-1:0]              control,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         synch_clear,
    input  logic                         synch_preset,
    input  logic                         synch_toggle,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             Q,
    output logic [$clog2(DEPTH+1)-1:0]   occ
`ifdef UMICH_SEQGEN_PARITY_EN
    ,
    output logic                         Q_par
`endif
);
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v, v_n, adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic [WIDTH-1:0] d_n [DEPTH];
    logic [WIDTH-1:0] sel;
    logic [OW-1:0] occ_n;
    logic full, in_take, run;
`ifdef UMICH_SEQGEN_PARITY_EN
    logic [DEPTH-1:0] p, p_n;
    assign Q_par = p[DEPTH-1];
`endif

    always_comb begin
        sel = data_in[(N_IN-1)*WIDTH +: WIDTH];
        for (int i = N_IN-1; i >= 0; i--)
            if (control[i]) sel = data_in[i*WIDTH +: WIDTH];
    end

    // a stage advances when some later stage is empty or the last stage is being popped
    always_comb begin
        full = 1'b1;
        for (int k = DEPTH-1; k >= 0; k--) begin
            adv[k] = out_ready | ~full;
            full = full & v[k];
        end
    end

    assign run = clear & ~synch_clear & ~synch_toggle;
    assign in_take = ~v[0] | adv[0];
    assign in_ready = run & in_take;
    assign out_valid = v[DEPTH-1] & ~synch_toggle;
    assign Q = d[DEPTH-1];

    always_comb begin
        v_n = v;
        d_n = d;
`ifdef UMICH_SEQGEN_PARITY_EN
        p_n = p;
`endif
        if (synch_clear) begin
            v_n = '0;
            if (synch_preset) begin
                v_n[0] = 1'b1;
                d_n[0] = PRESET_VAL;
`ifdef UMICH_SEQGEN_PARITY_EN
                p_n[0] = ^PRESET_VAL;
`endif
            end
        end else if (!synch_toggle) begin
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k-1]) begin
                    v_n[k] = v[k-1];
                    if (v[k-1]) d_n[k] = d[k-1];
`ifdef UMICH_SEQGEN_PARITY_EN
                    if (v[k-1]) p_n[k] = p[k-1];
`endif
                end
            end
            if (in_take) begin
                v_n[0] = in_valid;
                if (in_valid) d_n[0] = sel;
`ifdef UMICH_SEQGEN_PARITY_EN
                if (in_valid) p_n[0] = ^sel;
`endif
            end
        end
        occ_n = '0;
        for (int k = 0; k < DEPTH; k++) occ_n = occ_n + OW'(v_n[k]);
    end

    always_ff @(posedge clocked_on) begin
        if (!clear) begin
            v <= '0;
            d <= '{default: '0};
            occ <= '0;
`ifdef UMICH_SEQGEN_PARITY_EN
            p <= '0;
`endif
        end else begin
            v <= v_n;
            d <= d_n;
            occ <= occ_n;
`ifdef UMICH_SEQGEN_PARITY_EN
            p <= p_n;
`endif
        end
    end
endmodule

// File: tb/tb_umich_seqgen_pipe.sv
// tb_umich_seqgen_pipe: table vectors, directed corner sequences and random traffic against a token-queue model.
module tb_umich_seqgen_pipe;
    localparam int DEPTH = 2;
    localparam logic [7:0] PV = 8'h5A;

    logic clk = 0, clear = 0, in_valid = 0, out_ready = 0, sc = 0, sp = 0, st = 0;
    logic [23:0] data_in = '0;
    logic [2:0] control = '0;
    logic in_ready, out_valid;
    logic [7:0] q;
    logic [1:0] occ;
`ifdef UMICH_SEQGEN_PARITY_EN
    logic q_par;
`endif

    umich_seqgen_pipe #(.WIDTH(8), .N_IN(3), .DEPTH(DEPTH), .PRESET_VAL(PV)) dut (
        .clocked_on(clk), .clear(clear), .data_in(data_in), .control(control),
        .in_valid(in_valid), .in_ready(in_ready), .synch_clear(sc), .synch_preset(sp),
        .synch_toggle(st), .out_valid(out_valid), .out_ready(out_ready), .Q(q), .occ(occ)
`ifdef UMICH_SEQGEN_PARITY_EN
        , .Q_par(q_par)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int mpos[$];
    logic [7:0] mdat[$];
    logic [7:0] mq;

    typedef struct { logic [2:0] ctrl; logic [7:0] exp; } vec_t;
    vec_t tbl [7];

    task automatic check(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic logic [7:0] sel_ref();
        for (int i = 0; i < 3; i++) if (control[i]) return data_in[i*8 +: 8];
        return data_in[23:16];
    endfunction

    // token i sits at position mpos[i] (0 = input stage, DEPTH-1 = output), oldest first
    task automatic tick();
        int np[$];
        bit run, hv, pop, acc;
        int lim, s;
        #2;
        run = clear && !sc && !st;
        hv = mpos.size() > 0 && mpos[0] == DEPTH-1;
        pop = run && hv && out_ready;
        lim = DEPTH-1;
        s = pop ? 1 : 0;
        for (int i = s; i < mpos.size(); i++) begin
            np.push_back(mpos[i]+1 < lim ? mpos[i]+1 : lim);
            lim = np[np.size()-1] - 1;
        end
        acc = run && (np.size() == 0 || np[np.size()-1] > 0);
        check("in_ready", in_ready, acc);
        check("out_valid", out_valid, hv && !st);
        @(posedge clk);
        if (!clear) begin
            mpos.delete(); mdat.delete(); mq = 0;
        end else if (sc) begin
            mpos.delete(); mdat.delete();
            if (sp) begin mpos.push_back(0); mdat.push_back(PV); end
        end else if (!st) begin
            if (pop) void'(mdat.pop_front());
            mpos = np;
            if (acc && in_valid) begin mpos.push_back(0); mdat.push_back(sel_ref()); end
        end
        if (mpos.size() > 0 && mpos[0] == DEPTH-1) mq = mdat[0];
        #1;
        check("Q", q, mq);
        check("occ", occ, mpos.size());
`ifdef UMICH_SEQGEN_PARITY_EN
        check("Q_par", q_par, ^mq);
`endif
    endtask

    task automatic push(logic [7:0] val);
        control = 3'b001;
        data_in = {16'h0, val};
        in_valid = 1;
        tick();
    endtask

    initial begin
        tbl[0] = '{3'b110, 8'h22};
        tbl[1] = '{3'b000, 8'h33};
        tbl[2] = '{3'b001, 8'h11};
        tbl[3] = '{3'b111, 8'h11};
        tbl[4] = '{3'b100, 8'h33};
        tbl[5] = '{3'b010, 8'h22};
        tbl[6] = '{3'b101, 8'h11};

        clear = 0; in_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_Q", q, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_occ", occ, 0);
        check("rst_in_ready", in_ready, 0);
        mq = 0;
        clear = 1; in_valid = 0;
        #1;
        check("rel_in_ready", in_ready, 1);

        out_ready = 1;
        data_in = {8'h33, 8'h22, 8'h11};
        foreach (tbl[r]) begin
            control = tbl[r].ctrl; in_valid = 1;
            tick();
            in_valid = 0;
            tick();
            check("sel_Q", q, tbl[r].exp);
            check("sel_valid", out_valid, 1);
        end
        tick();

        for (int j = 0; j < 7; j++) begin
            if (j < 5) push(8'(j+1));
            else begin in_valid = 0; tick(); end
            check("tp_valid", out_valid, (j >= 1 && j <= 5));
            if (j >= 1 && j <= 5) check("tp_Q", q, j);
        end

        out_ready = 0;
        push(8'h0A);
        push(8'h0B);
        control = 3'b001; data_in = {16'h0, 8'h0C}; in_valid = 1;
        #1;
        check("bp_in_ready_full", in_ready, 0);
        tick();
        check("bp_occ", occ, 2);
        check("bp_Q", q, 8'h0A);
        out_ready = 1;
        #1;
        check("bp_push_with_pop", in_ready, 1);
        tick();
        check("bp_pop1", q, 8'h0B);
        check("bp_occ_swap", occ, 2);
        in_valid = 0;
        tick();
        check("bp_pop2", q, 8'h0C);

        out_ready = 0;
        push(8'h44);
        check("fl_occ2", occ, 2);
        in_valid = 0; sc = 1; sp = 1;
        tick();
        check("pre_occ", occ, 1);
        sc = 0; sp = 0;
        tick();
        check("pre_Q", q, PV);
        check("pre_valid", out_valid, 1);
        push(8'h66);
        in_valid = 0; sc = 1;
        tick();
        check("fl_occ0", occ, 0);
        check("fl_stale_Q", q, PV);
        sc = 0;

        push(8'h07);
        in_valid = 0;
        tick();
        st = 1; in_valid = 1; out_ready = 1;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 0);
            tick();
            check("hold_occ", occ, 1);
            check("hold_Q", q, 8'h07);
`ifdef UMICH_SEQGEN_PARITY_EN
            check("hold_Q_par", q_par, 1);
`endif
        end
        st = 0;

        for (int j = 0; j < 600; j++) begin
            clear = ($urandom_range(0, 49) != 0);
            sc = ($urandom_range(0, 19) == 0);
            sp = 1'($urandom);
            st = ($urandom_range(0, 9) == 0);
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            control = 3'($urandom);
            data_in = 24'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
